// File: rtl/axi_chan_pkg.sv
// Shared types and constants for the AXI-style channel blocks.
package axi_chan_pkg;

    typedef enum logic [1:0] {
        RX_EMPTY,
        RX_PART,
        RX_FULL
    } rx_fill_t;

    localparam int STAT_W = 16;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/axi_stall_monitor.sv
// Watches a stalled transmitter beat and flags VALID drops or data changes
// before acceptance; the error flag is sticky until reset.
module axi_stall_monitor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] xdata_i,
    output logic             prot_err_o
);

    logic             stall_q, stall_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    always_comb begin
        stall_d = valid_i & ~ready_i;
        data_d  = xdata_i;
        err_d   = err_q | (stall_q & (~valid_i | (xdata_i != data_q)));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign prot_err_o = err_q;

endmodule

// File: rtl/rx_channel_fifo.sv
// Receive side of the AXI-style channel: first-word-fall-through FIFO with a
// transmitter protocol monitor. Define RX_CHANNEL_FIFO_STATS_EN for beat/stall counters.
module rx_channel_fifo
    import axi_chan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       VALID,
    output logic                       READY,
    input  logic [WIDTH-1:0]           xDATA,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH):0]     count,
`ifdef RX_CHANNEL_FIFO_STATS_EN
    output logic [STAT_W-1:0]          beat_cnt,
    output logic [STAT_W-1:0]          stall_cnt,
`endif
    output logic                       prot_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    rx_fill_t         state_q, state_d;
    logic             push, pop;

    // READY depends only on reset and registered state, never on VALID.
    assign READY    = ~ARESET & (state_q != RX_FULL);
    assign rx_valid = ~ARESET & (state_q != RX_EMPTY);
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    assign push = VALID & READY;
    assign pop  = rx_valid & rx_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        case (state_q)
            RX_EMPTY: begin
                if (push) state_d = RX_PART;
            end
            RX_PART: begin
                if (push && !pop && count_q == CW'(DEPTH - 1)) begin
                    state_d = RX_FULL;
                end else if (pop && !push && count_q == CW'(1)) begin
                    state_d = RX_EMPTY;
                end
            end
            RX_FULL: begin
                if (pop) state_d = RX_PART;
            end
            default: state_d = RX_EMPTY;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RX_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= xDATA;
        end
    end

    axi_stall_monitor #(
        .WIDTH(WIDTH)
    ) u_stall_monitor (
        .clk       (ACLK),
        .srst      (ARESET),
        .valid_i   (VALID),
        .ready_i   (READY),
        .xdata_i   (xDATA),
        .prot_err_o(prot_err)
    );

`ifdef RX_CHANNEL_FIFO_STATS_EN
    logic [STAT_W-1:0] beat_cnt_q;
    logic [STAT_W-1:0] stall_cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) beat_cnt_q <= sat_inc(beat_cnt_q);
            if (VALID && !READY) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
